// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch stage; IFETCH_MISALIGN_TRAP_EN traps misaligned redirects into FAULT
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;
    state_t state, state_n;
    logic [31:0] pc, pc_n, req_pc, req_pc_n, out_instr_n, out_pc_n, tgt;
    logic squash, squash_n, bad;
`ifdef IFETCH_MISALIGN_TRAP_EN
    assign tgt = redirect_pc;
    assign bad = |redirect_pc[1:0];
    assign fetch_fault = state == FAULT;
`else
    assign tgt = {redirect_pc[31:2], 2'b00};
    assign bad = 1'b0 & |redirect_pc[1:0];
    assign fetch_fault = 1'b0;
`endif
    assign imem_req_valid = state == REQ;
    assign imem_addr = pc;
    assign out_valid = state == HOLD;
    always_comb begin
        state_n = state;
        pc_n = pc;
        req_pc_n = req_pc;
        squash_n = squash;
        out_instr_n = out_instr;
        out_pc_n = out_pc;
        if (redirect_valid && state != FAULT) begin
            pc_n = tgt;
            if (bad) begin
                state_n = FAULT;
                out_pc_n = redirect_pc;
            end else if (state == REQ && imem_req_ready) begin
                state_n = WAIT;
                req_pc_n = pc;
                squash_n = 1'b1;
            end else if (state == WAIT && !imem_rsp_valid) begin
                squash_n = 1'b1;
            end else begin
                state_n = REQ;
                squash_n = 1'b0;
            end
        end else begin
            case (state)
                IDLE: state_n = REQ;
                REQ: if (imem_req_ready) begin
                    state_n = WAIT;
                    req_pc_n = pc;
                end
                WAIT: if (imem_rsp_valid) begin
                    if (squash) begin
                        squash_n = 1'b0;
                        state_n = REQ;
                    end else begin
                        out_instr_n = imem_rsp_data;
                        out_pc_n = req_pc;
                        pc_n = req_pc + 32'd4;
                        state_n = HOLD;
                    end
                end
                HOLD: if (out_ready) state_n = REQ;
                default: state_n = state;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc <= RESET_PC;
            req_pc <= RESET_PC;
            squash <= 1'b0;
            out_instr <= 32'h0000_0013;
            out_pc <= 32'h0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            req_pc <= req_pc_n;
            squash <= squash_n;
            out_instr <= out_instr_n;
            out_pc <= out_pc_n;
        end
    end
endmodule
